// File: rtl/dist_pkg.sv
// Shared types and constants for the distance guard: zone encoding, sample width,
// default clamp, and small helpers used by the guard and its averager.
package dist_pkg;

  localparam int DIST_W     = 16;
  localparam int DEF_MAX_CM = 400;

  typedef enum logic [1:0] {
    ZONE_FAR   = 2'd0,
    ZONE_NEAR  = 2'd1,
    ZONE_STOP  = 2'd2,
    ZONE_FAULT = 2'd3
  } zone_e;

  function automatic logic [DIST_W-1:0] clamp_cm(input logic [DIST_W-1:0] d,
                                                 input logic [DIST_W-1:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  function automatic logic is_halt(input zone_e z);
    return (z == ZONE_STOP) || (z == ZONE_FAULT);
  endfunction

endpackage

// File: rtl/dist_avg.sv
// Power-of-two moving average over accepted distance samples. avg_cm/avg_valid
// update the cycle after an accept, once the window has been filled.
module dist_avg
  import dist_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              accept,
  input  logic [DIST_W-1:0] sample,
  output logic [DIST_W-1:0] avg_cm,
  output logic              avg_valid
);

  localparam int WIN   = 1 << AVG_LOG2;
  localparam int SUM_W = DIST_W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] FILL_LAST = (AVG_LOG2 + 1)'(WIN - 1);
  localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2 + 1)'(WIN);

  logic [DIST_W-1:0]   slot_q [WIN];
  logic [AVG_LOG2-1:0] ptr_q;
  logic [AVG_LOG2:0]   fill_q;
  logic [SUM_W-1:0]    sum_q;
  logic [SUM_W-1:0]    sum_nx;
  logic                full_nx;

  // The slot under ptr_q is always the oldest sample, so it is what leaves the sum.
  assign sum_nx  = sum_q + SUM_W'(sample) - SUM_W'(slot_q[ptr_q]);
  assign full_nx = (fill_q >= FILL_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIN; i++) slot_q[i] <= '0;
      ptr_q     <= '0;
      fill_q    <= '0;
      sum_q     <= '0;
      avg_cm    <= '0;
      avg_valid <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < WIN; i++) slot_q[i] <= '0;
      ptr_q     <= '0;
      fill_q    <= '0;
      sum_q     <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (accept) begin
        slot_q[ptr_q] <= sample;
        ptr_q         <= ptr_q + 1'b1;
        sum_q         <= sum_nx;
        if (fill_q != FILL_FULL) fill_q <= fill_q + 1'b1;
        if (full_nx) begin
          avg_valid <= 1'b1;
          avg_cm    <= DIST_W'(sum_nx >> AVG_LOG2);
        end
      end
    end
  end

endmodule

// File: rtl/dist_guard.sv
// Proximity guard: averages ranger samples, classifies zones with hysteresis and
// drives stop. Define DIST_GUARD_STOP_LATCH_EN to make stop sticky until clear_stop.
//
//   state      | meaning
//   ZONE_FAR   | clear path, stop released
//   ZONE_NEAR  | object approaching, stop released
//   ZONE_STOP  | object too close, stop asserted
//   ZONE_FAULT | no valid average (reset or sample timeout), stop asserted
module dist_guard
  import dist_pkg::*;
#(
  parameter int AVG_LOG2    = 2,
  parameter int MAX_CM      = DEF_MAX_CM,
  parameter int NEAR_CM     = 50,
  parameter int STOP_CM     = 15,
  parameter int HYST_CM     = 5,
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIST_W-1:0] dist_cm,
  input  logic              dist_valid,
  input  logic              clear_stop,
  output logic [DIST_W-1:0] avg_cm,
  output logic              avg_valid,
  output logic [1:0]        zone,
  output logic              stop
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]  TMO_END  = TMO_W'(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [DIST_W-1:0] MAX_T    = DIST_W'(MAX_CM);
  localparam logic [DIST_W-1:0] STOP_T   = DIST_W'(STOP_CM);
  localparam logic [DIST_W-1:0] NEAR_T   = DIST_W'(NEAR_CM);
  localparam logic [DIST_W-1:0] STOP_X   = DIST_W'(STOP_CM + HYST_CM);
  localparam logic [DIST_W-1:0] NEAR_X   = DIST_W'(NEAR_CM + HYST_CM);

  logic              accept;
  logic [DIST_W-1:0] sample;
  logic [TMO_W-1:0]  tmo_q;
  logic              tmo_hit;
  zone_e             zone_q;
  zone_e             zone_nx;
  logic              stop_q;

  function automatic zone_e classify(input zone_e cur, input logic [DIST_W-1:0] a);
    zone_e nz;
    nz = cur;
    case (cur)
      ZONE_NEAR: begin
        if (a < STOP_T)       nz = ZONE_STOP;
        else if (a >= NEAR_X) nz = ZONE_FAR;
      end
      ZONE_STOP: begin
        if (a >= NEAR_X)      nz = ZONE_FAR;
        else if (a >= STOP_X) nz = ZONE_NEAR;
      end
      default: begin
        if (a < STOP_T)       nz = ZONE_STOP;
        else if (a < NEAR_T)  nz = ZONE_NEAR;
        else                  nz = ZONE_FAR;
      end
    endcase
    return nz;
  endfunction

  assign accept = dist_valid && (dist_cm != '0);
  assign sample = clamp_cm(dist_cm, MAX_T);
  // An accept landing on the terminal cycle keeps the counter from ever reaching it.
  assign tmo_hit = !accept && (tmo_q == TMO_LAST);

  dist_avg #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk       (clk),
    .reset     (reset),
    .flush     (tmo_hit),
    .accept    (accept),
    .sample    (sample),
    .avg_cm    (avg_cm),
    .avg_valid (avg_valid)
  );

  always_ff @(posedge clk) begin
    if (reset)                tmo_q <= '0;
    else if (accept)          tmo_q <= '0;
    else if (tmo_q != TMO_END) tmo_q <= tmo_q + 1'b1;
  end

  assign zone_nx = avg_valid ? classify(zone_q, avg_cm) : zone_q;

`ifndef DIST_GUARD_STOP_LATCH_EN
  logic unused_clear_stop;
  assign unused_clear_stop = clear_stop;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      zone_q <= ZONE_FAULT;
      stop_q <= 1'b1;
    end else if (tmo_hit) begin
      zone_q <= ZONE_FAULT;
      stop_q <= 1'b1;
    end else begin
      zone_q <= zone_nx;
`ifdef DIST_GUARD_STOP_LATCH_EN
      stop_q <= is_halt(zone_nx) || (stop_q && !(clear_stop && !is_halt(zone_q)));
`else
      stop_q <= is_halt(zone_nx);
`endif
    end
  end

  assign zone = zone_q;
  assign stop = stop_q;

endmodule
